// File: rtl/prog_loader.sv
// Program loader for the n1 core: takes a LEN / data / CHK byte frame, writes 16-bit words
// into program RAM and raises cpu_run once the image checksum is verified.
module prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 255,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_run,
  output logic [ADDR_W-1:0] words_ld
);

  typedef enum logic [2:0] {
    IDLE, HDR, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERROR
  } state_t;

  localparam logic [8:0]        DEPTH_L = 9'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_ADDR);

  state_t     state, next_state;
  logic [7:0] n_words, sum, index, hi_byte, byte_sum;
  logic       xfer, len_bad, last_word, next_ready, next_busy;

  assign xfer      = in_valid & in_ready;
  assign byte_sum  = sum + in_data;
  assign len_bad   = (in_data == 8'd0) || ({1'b0, in_data} > DEPTH_L);
  assign last_word = (index == n_words - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE, ERROR: if (start) next_state = HDR;
        HDR:               if (xfer)  next_state = len_bad ? ERROR : DATA_HI;
        DATA_HI:           if (xfer)  next_state = DATA_LO;
        DATA_LO:           if (xfer)  next_state = WRITE;
        WRITE:             next_state = last_word ? CHK : DATA_HI;
        CHK:               if (xfer)  next_state = (byte_sum == 8'd0) ? DONE : ERROR;
        default:           next_state = IDLE;
      endcase
    end
  end

  // Handshake and busy are decoded from the next state so they can be registered.
  always_comb begin
    next_ready = 1'b0;
    next_busy  = 1'b0;
    case (next_state)
      HDR, DATA_HI, DATA_LO, CHK: begin
        next_ready = 1'b1;
        next_busy  = 1'b1;
      end
      WRITE:   next_busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_run   <= 1'b0;
      words_ld  <= '0;
      sum       <= '0;
      index     <= '0;
      n_words   <= '0;
      hi_byte   <= '0;
    end else begin
      in_ready <= next_ready;
      busy     <= next_busy;
      mem_we   <= (next_state == WRITE);
      if (abort) begin
        done    <= 1'b0;
        error   <= 1'b0;
        cpu_run <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (start) begin
              done     <= 1'b0;
              error    <= 1'b0;
              cpu_run  <= 1'b0;
              words_ld <= '0;
              sum      <= '0;
              index    <= '0;
            end
          end
          HDR: begin
            if (xfer) begin
              n_words <= in_data;
              sum     <= in_data;
              if (len_bad) error <= 1'b1;
            end
          end
          DATA_HI: begin
            if (xfer) begin
              hi_byte <= in_data;
              sum     <= byte_sum;
            end
          end
          // Address and data are staged here so they are stable for the whole WRITE cycle.
          DATA_LO: begin
            if (xfer) begin
              sum       <= byte_sum;
              mem_wdata <= {hi_byte, in_data};
              mem_addr  <= BASE_L + ADDR_W'(index);
            end
          end
          WRITE: begin
            words_ld <= ADDR_W'({1'b0, index} + 9'd1);
            if (!last_word) index <= index + 8'd1;
          end
          CHK: begin
            if (xfer) begin
              if (byte_sum == 8'd0) begin
                done    <= 1'b1;
                cpu_run <= 1'b1;
              end else begin
                error <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus random frames checked against a
// frame-level reference model of the expected RAM writes and final flags.
module tb_prog_loader;

  localparam int ADDR_W    = 8;
  localparam int DEPTH     = 16;
  localparam int BASE_ADDR = 0;
  localparam int HS_LIMIT  = 64;

  typedef logic [7:0] byte_q_t [$];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_run;
  logic [ADDR_W-1:0] words_ld;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] obs_addr [$];
  logic [15:0]       obs_data [$];
  logic [ADDR_W-1:0] exp_addr [$];
  logic [15:0]       exp_data [$];
  logic              exp_done;
  logic              exp_err;
  int                exp_words;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_run(cpu_run), .words_ld(words_ld)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: records every RAM write and checks the handshake is closed while writing.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      checkOutput("ready_low_in_write", {31'd0, in_ready}, 32'd0);
      checkOutput("busy_in_write", {31'd0, busy}, 32'd1);
    end
  end

  // Reference model: from the frame bytes alone, derive the writes and final flags.
  task automatic build_expect(input byte_q_t f);
    int n;
    logic [7:0] total;
    exp_addr.delete();
    exp_data.delete();
    n = int'(f[0]);
    if (n == 0 || n > DEPTH) begin
      exp_done  = 1'b0;
      exp_err   = 1'b1;
      exp_words = 0;
    end else begin
      total = 8'd0;
      foreach (f[i]) total += f[i];
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(ADDR_W'((BASE_ADDR + i) % (1 << ADDR_W)));
        exp_data.push_back({f[1+2*i], f[2+2*i]});
      end
      exp_words = n;
      exp_done  = (total == 8'd0);
      exp_err   = !exp_done;
    end
  endtask

  task automatic start_load();
    obs_addr.delete();
    obs_data.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input byte_q_t frame, input int gap_max);
    foreach (frame[i]) begin
      int waited;
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 1)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = frame[i];
      waited   = 0;
      while (!in_ready && waited < HS_LIMIT) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("handshake_bound", {31'd0, waited < HS_LIMIT}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_load(input string tag);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_write_count"}, obs_addr.size(), exp_addr.size());
    foreach (exp_addr[i]) begin
      if (i < obs_addr.size()) begin
        checkOutput({tag, "_addr"}, {24'd0, obs_addr[i]}, {24'd0, exp_addr[i]});
        checkOutput({tag, "_data"}, {16'd0, obs_data[i]}, {16'd0, exp_data[i]});
      end
    end
    checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    checkOutput({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
    checkOutput({tag, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, exp_done});
    checkOutput({tag, "_words_ld"}, {24'd0, words_ld}, exp_words);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    checkOutput({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_error"}, {31'd0, error}, 32'd0);
    checkOutput({tag, "_cpu_run"}, {31'd0, cpu_run}, 32'd0);
    checkOutput({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    checkOutput({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    checkOutput({tag, "_words_ld"}, {24'd0, words_ld}, 32'd0);
  endtask

  initial begin
    byte_q_t f;
    int      wr_before;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] good frame, continuous valid");
    f = '{8'h02, 8'h12, 8'h01, 8'h70, 8'h01, 8'h7A};
    build_expect(f);
    start_load();
    applyStimulus(f, 0);
    check_load("good");

    $display("[TB] bad checksum");
    f = '{8'h02, 8'h12, 8'h01, 8'h70, 8'h01, 8'h7B};
    build_expect(f);
    start_load();
    applyStimulus(f, 0);
    check_load("badchk");

    $display("[TB] length errors");
    f = '{8'h00};
    build_expect(f);
    start_load();
    applyStimulus(f, 0);
    check_load("len0");
    f = '{8'hFF};
    build_expect(f);
    start_load();
    applyStimulus(f, 0);
    check_load("lenFF");
    f = '{8'(DEPTH + 1)};
    build_expect(f);
    start_load();
    applyStimulus(f, 0);
    check_load("len_over");

    $display("[TB] full-depth frame");
    f = '{8'(DEPTH)};
    for (int j = 0; j < 2 * DEPTH; j++) f.push_back(8'($urandom));
    begin
      logic [7:0] s;
      s = 8'd0;
      foreach (f[j]) s += f[j];
      f.push_back(8'd0 - s);
    end
    build_expect(f);
    start_load();
    applyStimulus(f, 2);
    check_load("full_depth");

    $display("[TB] good frame with valid gaps");
    f = '{8'h02, 8'h12, 8'h01, 8'h70, 8'h01, 8'h7A};
    build_expect(f);
    start_load();
    applyStimulus(f, 5);
    check_load("gaps");

    $display("[TB] abort after first word");
    start_load();
    f = '{8'h02, 8'h12, 8'h01};
    applyStimulus(f, 0);
    checkOutput("we_latency", {31'd0, mem_we}, 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("abort_writes", obs_addr.size(), 1);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("abort_words_ld", {24'd0, words_ld}, 32'd1);
    checkOutput("abort_flags", {29'd0, done, error, cpu_run}, 32'd0);

    $display("[TB] start and abort together");
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("start_abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("start_abort_ready", {31'd0, in_ready}, 32'd0);

    $display("[TB] reset mid DATA_LO");
    start_load();
    f = '{8'h02, 8'h12, 8'h01, 8'h70};
    applyStimulus(f, 0);
    wr_before = obs_addr.size();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_no_write", obs_addr.size(), wr_before);
    f = '{8'h02, 8'h12, 8'h01, 8'h70, 8'h01, 8'h7A};
    build_expect(f);
    start_load();
    applyStimulus(f, 0);
    check_load("after_reset");

    $display("[TB] random frames");
    for (int k = 0; k < 10; k++) begin
      byte_q_t    rf;
      int         n;
      logic [7:0] s;
      rf = {};
      if ($urandom_range(4, 0) == 0)
        n = ($urandom_range(1, 0) == 1) ? 0 : int'($urandom_range(255, DEPTH + 1));
      else
        n = int'($urandom_range(DEPTH, 1));
      rf.push_back(8'(n));
      if (n >= 1 && n <= DEPTH) begin
        for (int j = 0; j < 2 * n; j++) rf.push_back(8'($urandom));
        s = 8'd0;
        foreach (rf[j]) s += rf[j];
        if ($urandom_range(1, 0) == 1) rf.push_back(8'd0 - s);
        else rf.push_back(8'($urandom));
      end
      build_expect(rf);
      start_load();
      applyStimulus(rf, int'($urandom_range(3, 0)));
      check_load("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
